// File: rtl/test_ram_arbiter_pkg.sv
// Shared encodings for the test RAM arbiter: FSM states, owner ids, open-bus value.
package test_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;

endpackage

// File: rtl/test_ram_arb_pick.sv
// Combinational grant select between the cpu and dbg requesters.
// TEST_RAM_ARB_RR_EN: round-robin on contention; otherwise dbg has fixed priority.
module test_ram_arb_pick
    import test_ram_arbiter_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   dbg_req_i,
`ifdef TEST_RAM_ARB_RR_EN
    input  owner_e last_i,
`endif
    output logic   grant_vld_o,
    output owner_e grant_o
);

    always_comb begin
        grant_vld_o = cpu_req_i | dbg_req_i;
        grant_o     = OWN_CPU;
        if (cpu_req_i && dbg_req_i) begin
`ifdef TEST_RAM_ARB_RR_EN
            // Whoever was not granted last wins the tie.
            if (last_i == OWN_CPU) grant_o = OWN_DBG;
            else                   grant_o = OWN_CPU;
`else
            grant_o = OWN_DBG;
`endif
        end else if (dbg_req_i) begin
            grant_o = OWN_DBG;
        end
    end

endmodule

// File: rtl/test_ram_arbiter.sv
// Two-port (cpu, dbg) arbiter in front of the single-port synchronous test RAM.
// Optional round-robin arbitration via TEST_RAM_ARB_RR_EN (see test_ram_arb_pick).
module test_ram_arbiter
    import test_ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 24,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr,
    input  logic [7:0]                cpu_wdata,
    output logic                      cpu_ack,
    output logic [7:0]                cpu_rdata,
    input  logic                      dbg_req,
    input  logic                      dbg_we,
    input  logic [ADDR_WIDTH-1:0]     dbg_addr,
    input  logic [7:0]                dbg_wdata,
    output logic                      dbg_ack,
    output logic [7:0]                dbg_rdata,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]                ram_wdata,
    input  logic [7:0]                ram_rdata
);

    localparam logic [1:0] CNT_INIT = 2'(RAM_LATENCY - 1);

    state_e                    state_q, state_d;
    owner_e                    owner_q, owner_d;
    logic                      we_q, we_d;
    logic                      oor_q, oor_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                wdata_q, wdata_d;
    logic [7:0]                cpu_rdata_q, cpu_rdata_d;
    logic [7:0]                dbg_rdata_q, dbg_rdata_d;
    logic [1:0]                cnt_q, cnt_d;

    logic                      grant_vld;
    owner_e                    grant;
    logic                      sel_we;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [7:0]                sel_wdata;
    logic [7:0]                rd_val;

    test_ram_arb_pick u_pick (
        .cpu_req_i   (cpu_req),
        .dbg_req_i   (dbg_req),
`ifdef TEST_RAM_ARB_RR_EN
        .last_i      (owner_q),
`endif
        .grant_vld_o (grant_vld),
        .grant_o     (grant)
    );

    assign sel_we    = (grant == OWN_DBG) ? dbg_we    : cpu_we;
    assign sel_addr  = (grant == OWN_DBG) ? dbg_addr  : cpu_addr;
    assign sel_wdata = (grant == OWN_DBG) ? dbg_wdata : cpu_wdata;
    assign rd_val    = oor_q ? OPEN_BUS_DATA : ram_rdata;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        oor_d       = oor_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    owner_d = grant;
                    we_d    = sel_we;
                    addr_d  = sel_addr[RAM_ADDR_WIDTH-1:0];
                    oor_d   = |sel_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];
                    wdata_d = sel_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    // Last WAIT cycle is exactly when the RAM's read data is valid.
                    if (!we_q) begin
                        if (owner_q == OWN_DBG) dbg_rdata_d = rd_val;
                        else                    cpu_rdata_d = rd_val;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Out-of-range accesses never strobe the RAM, so writes there are dropped.
    assign ram_en    = (state_q == ISSUE) && !oor_q;
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign cpu_ack   = (state_q == ACK) && (owner_q == OWN_CPU);
    assign dbg_ack   = (state_q == ACK) && (owner_q == OWN_DBG);
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_test_ram_arbiter.sv
// Directed bench for test_ram_arbiter: latency-1 instance (u0) with a RAM model,
// plus a latency-3 instance (u3) for the back-to-back throughput case.
module tb_test_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        c0_req = 0, c0_we = 0, d0_req = 0, d0_we = 0;
    logic [23:0] c0_addr = '0, d0_addr = '0;
    logic [7:0]  c0_wdata = '0, d0_wdata = '0;
    logic        c0_ack, d0_ack, r0_en, r0_we;
    logic [7:0]  c0_rdata, d0_rdata, r0_wdata, r0_rdata;
    logic [15:0] r0_addr;

    logic        c3_req = 0, c3_we = 0, d3_req = 0, d3_we = 0;
    logic [23:0] c3_addr = '0, d3_addr = '0;
    logic [7:0]  c3_wdata = '0, d3_wdata = '0;
    logic        c3_ack, d3_ack, r3_en, r3_we;
    logic [7:0]  c3_rdata, d3_rdata, r3_wdata, r3_rdata;
    logic [15:0] r3_addr;

    logic [7:0]  mem0 [0:65535];
    logic [7:0]  mem3 [0:65535];
    logic [7:0]  p0, p1, p2;

    int n_err = 0;
    int n_chk = 0;
    int cacks[2], dacks[2];

    always #5 clk = ~clk;

    test_ram_arbiter u0 (
        .clk(clk), .rst(rst),
        .cpu_req(c0_req), .cpu_we(c0_we), .cpu_addr(c0_addr), .cpu_wdata(c0_wdata),
        .cpu_ack(c0_ack), .cpu_rdata(c0_rdata),
        .dbg_req(d0_req), .dbg_we(d0_we), .dbg_addr(d0_addr), .dbg_wdata(d0_wdata),
        .dbg_ack(d0_ack), .dbg_rdata(d0_rdata),
        .ram_en(r0_en), .ram_we(r0_we), .ram_addr(r0_addr), .ram_wdata(r0_wdata),
        .ram_rdata(r0_rdata)
    );

    test_ram_arbiter #(.RAM_LATENCY(3)) u3 (
        .clk(clk), .rst(rst),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_ack(c3_ack), .cpu_rdata(c3_rdata),
        .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr), .dbg_wdata(d3_wdata),
        .dbg_ack(d3_ack), .dbg_rdata(d3_rdata),
        .ram_en(r3_en), .ram_we(r3_we), .ram_addr(r3_addr), .ram_wdata(r3_wdata),
        .ram_rdata(r3_rdata)
    );

    // RAM models: preload a few known bytes while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            mem0[16'h0000] <= 8'h11;
            mem0[16'h1234] <= 8'hA5;
            mem3[16'h0020] <= 8'h5A;
        end else if (r0_en) begin
            if (r0_we) mem0[r0_addr] <= r0_wdata;
            r0_rdata <= mem0[r0_addr];
        end
    end

    always @(posedge clk) begin
        if (!rst && r3_en) begin
            if (r3_we) mem3[r3_addr] <= r3_wdata;
            p0 <= mem3[r3_addr];
        end
        p1 <= p0;
        p2 <= p1;
    end
    assign r3_rdata = p2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        dbg;
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic        exp_en;
        logic [7:0]  exp_own;
        logic [7:0]  exp_oth;
    } vec_t;

    vec_t vecs[9];

    // One access on u0 (latency 1): request at cycle 0, ack expected at cycle 3.
    task automatic run_vec(input vec_t v, input string tag);
        int ack_c, own_n, oth_n, en_c, en_n;
        logic [15:0] en_a;
        logic en_w;
        logic [7:0] en_d, own_r, oth_r;
        ack_c = -1; own_n = 0; oth_n = 0; en_c = -1; en_n = 0;
        en_a = '0; en_w = 0; en_d = '0; own_r = 'x; oth_r = 'x;
        @(posedge clk); #1;
        if (v.dbg) begin
            d0_req = 1; d0_we = v.we; d0_addr = v.addr; d0_wdata = v.wdata;
        end else begin
            c0_req = 1; c0_we = v.we; c0_addr = v.addr; c0_wdata = v.wdata;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (r0_en) begin
                en_n++;
                if (en_c < 0) begin en_c = c; en_a = r0_addr; en_w = r0_we; en_d = r0_wdata; end
            end
            if (v.dbg ? c0_ack : d0_ack) oth_n++;
            if (v.dbg ? d0_ack : c0_ack) begin
                own_n++;
                if (ack_c < 0) begin
                    ack_c = c;
                    own_r = v.dbg ? d0_rdata : c0_rdata;
                    oth_r = v.dbg ? c0_rdata : d0_rdata;
                end
                c0_req = 0; d0_req = 0;
            end
        end
        chk({tag, "_ack_cycle"}, ack_c, 3);
        chk({tag, "_ack_count"}, own_n, 1);
        chk({tag, "_other_ack"}, oth_n, 0);
        chk({tag, "_en_count"}, en_n, 32'(v.exp_en));
        if (v.exp_en) begin
            chk({tag, "_en_cycle"}, en_c, 1);
            chk({tag, "_ram_addr"}, 32'(en_a), 32'(v.addr[15:0]));
            chk({tag, "_ram_we"}, 32'(en_w), 32'(v.we));
            if (v.we) chk({tag, "_ram_wdata"}, 32'(en_d), 32'(v.wdata));
        end
        chk({tag, "_own_rdata"}, 32'(own_r), 32'(v.exp_own));
        chk({tag, "_oth_rdata"}, 32'(oth_r), 32'(v.exp_oth));
    endtask

    // Both requesters raise req together; each drops after its ncpu/ndbg-th ack.
    task automatic contend(input int ncpu, input int ndbg, input string tag);
        int nc, nd, both;
        nc = 0; nd = 0; both = 0;
        for (int i = 0; i < 2; i++) begin cacks[i] = -1; dacks[i] = -1; end
        @(posedge clk); #1;
        c0_req = 1; c0_we = 0; c0_addr = 24'h001234;
        d0_req = 1; d0_we = 0; d0_addr = 24'h000010;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c0_ack && d0_ack) both++;
            if (c0_ack) begin
                if (nc < 2) cacks[nc] = c;
                nc++;
                if (nc >= ncpu) c0_req = 0;
            end
            if (d0_ack) begin
                if (nd < 2) dacks[nd] = c;
                nd++;
                if (nd >= ndbg) d0_req = 0;
            end
        end
        c0_req = 0; d0_req = 0;
        chk({tag, "_both_acks"}, both, 0);
        chk({tag, "_cpu_acks"}, nc, ncpu);
        chk({tag, "_dbg_acks"}, nd, ndbg);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n_en, n_ack, cnt;
        int en3[3], ack3[3];
        logic [7:0] rd3[3];

        vecs[0] = '{1'b1, 1'b1, 24'h000010, 8'h3C, 1'b1, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 24'h000010, 8'h00, 1'b1, 8'h3C, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 24'h001234, 8'h00, 1'b1, 8'hA5, 8'h3C};
        vecs[3] = '{1'b0, 1'b0, 24'h010000, 8'h00, 1'b0, 8'hFF, 8'h3C};
        vecs[4] = '{1'b0, 1'b1, 24'h010000, 8'h55, 1'b0, 8'hFF, 8'h3C};
        vecs[5] = '{1'b0, 1'b0, 24'h000000, 8'h00, 1'b1, 8'h11, 8'h3C};
        vecs[6] = '{1'b0, 1'b1, 24'h00ABCD, 8'h77, 1'b1, 8'h11, 8'h3C};
        vecs[7] = '{1'b1, 1'b0, 24'h00ABCD, 8'h00, 1'b1, 8'h77, 8'h11};
        vecs[8] = '{1'b0, 1'b0, 24'h001234, 8'h00, 1'b1, 8'hA5, 8'h77};

        repeat (3) @(negedge clk);
        chk("rst_outputs", {c0_ack, d0_ack, r0_en, r0_we}, 0);
        chk("rst_ram_addr", 32'(r0_addr), 0);
        chk("rst_ram_wdata", 32'(r0_wdata), 0);
        chk("rst_rdata", {16'h0, c0_rdata, d0_rdata}, 0);
        rst = 0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Last grant above was cpu, so both arbitration modes give dbg first here.
        contend(1, 1, "contA");
        chk("contA_dbg_first", dacks[0], 3);
        chk("contA_cpu_next", cacks[0], 7);
        contend(1, 2, "contB");
`ifdef TEST_RAM_ARB_RR_EN
        chk("contB_dbg1", dacks[0], 3);
        chk("contB_cpu", cacks[0], 7);
        chk("contB_dbg2", dacks[1], 11);
`else
        chk("contB_dbg1", dacks[0], 3);
        chk("contB_dbg2", dacks[1], 7);
        chk("contB_cpu", cacks[0], 11);
`endif
        chk("contB_cpu_rdata", 32'(c0_rdata), 32'h A5);

        // Latency 3, req held: one access every 6 cycles.
        n_en = 0; n_ack = 0;
        for (int i = 0; i < 3; i++) begin en3[i] = -1; ack3[i] = -1; rd3[i] = '0; end
        @(posedge clk); #1;
        c3_req = 1; c3_we = 0; c3_addr = 24'h000020;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (r3_en) begin if (n_en < 3) en3[n_en] = c; n_en++; end
            if (d3_ack) n_err += 0;
            if (c3_ack) begin
                if (n_ack < 3) begin ack3[n_ack] = c; rd3[n_ack] = c3_rdata; end
                n_ack++;
                if (n_ack == 3) c3_req = 0;
            end
        end
        chk("lat3_en_count", n_en, 3);
        chk("lat3_ack_count", n_ack, 3);
        chk("lat3_en0", en3[0], 1);
        chk("lat3_en1", en3[1], 7);
        chk("lat3_en2", en3[2], 13);
        chk("lat3_ack0", ack3[0], 5);
        chk("lat3_ack1", ack3[1], 11);
        chk("lat3_ack2", ack3[2], 17);
        chk("lat3_rdata0", 32'(rd3[0]), 32'h5A);
        chk("lat3_rdata2", 32'(rd3[2]), 32'h5A);
        chk("lat3_dbg_ack", 32'(d3_ack), 0);

        // Reset during WAIT of a cpu read aborts it asynchronously.
        @(posedge clk); #1;
        c0_req = 1; c0_we = 0; c0_addr = 24'h001234;
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_outputs", {c0_ack, d0_ack, r0_en, r0_we}, 0);
        chk("arst_ram_addr", 32'(r0_addr), 0);
        chk("arst_rdata", {16'h0, c0_rdata, d0_rdata}, 0);
        cnt = 0;
        c0_req = 0;
        for (int c = 0; c < 3; c++) begin @(negedge clk); if (c0_ack) cnt++; end
        rst = 0;
        for (int c = 0; c < 5; c++) begin @(negedge clk); if (c0_ack) cnt++; end
        chk("arst_no_ack", cnt, 0);
        run_vec('{1'b0, 1'b0, 24'h001234, 8'h00, 1'b1, 8'hA5, 8'h00}, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/test_ram_arbiter.md
Name: test_ram_arbiter

Overview:
- Shares the single-port synchronous test RAM between two requesters:
  - the 65c816 core's memory port (cpu_*);
  - the debug/loader port (dbg_*), which preloads programs and inspects memory.
- Sequences each access (issue, RAM latency wait, registered response) and returns one-cycle ack pulses.
- Sits between the cpu and the test RAM in the simulation top.

Parameters:
- ADDR_WIDTH, 24, requester address width (65c816 bank:address).
- RAM_ADDR_WIDTH, 16, RAM address width; only the low bits drive the RAM.
- RAM_LATENCY, 1, cycles from ram_en to valid ram_rdata; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  cpu access request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  cpu address.
- cpu_wdata  in  8  cpu write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data, valid while cpu_ack is high, held afterwards.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the cpu_* set, for the debug/loader port.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable, qualified by ram_en.
- ram_addr  out  RAM_ADDR_WIDTH  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid RAM_LATENCY cycles after the ram_en cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All acks, ram_en, ram_we = 0.
  - ram_addr, ram_wdata, cpu_rdata, dbg_rdata = 0.
  - Owner register and round-robin pointer = cpu.
  - Asserting rst mid-access aborts it: no ack is produced, and an in-flight write may or may not have reached the RAM.
- IDLE:
  - Samples the req lines; req is only sampled in IDLE.
  - If any req is high: latch owner, we, addr and wdata, then go to ISSUE.
  - Arbitration: fixed priority, dbg over cpu, when both are high in the same cycle.
- ISSUE (1 cycle):
  - ram_en = 1; ram_we, ram_addr and ram_wdata come from the latched values.
  - Go to WAIT.
- WAIT (RAM_LATENCY cycles):
  - Down-counter loaded with RAM_LATENCY-1 on entry.
  - In the final WAIT cycle, capture ram_rdata into the owner's rdata register (reads only).
  - Then go to ACK.
- ACK (1 cycle):
  - Owner's ack = 1, other ack = 0; the non-owner's rdata is unchanged.
  - Go to IDLE.
- Timing:
  - Request seen in IDLE at cycle t gives ack at cycle t+2+RAM_LATENCY.
  - Throughput: one access per RAM_LATENCY+3 cycles.
- Writes follow the identical sequence. rdata is not updated on a write.
- Back-to-back: if the owner's req is still high in the IDLE after ACK, it is treated as a new request.
- Out-of-range access (any addr bit at or above RAM_ADDR_WIDTH set):
  - ISSUE keeps ram_en = 0, so the write is dropped.
  - A read returns OPEN_BUS_DATA (8'hFF).
  - Ack timing is unchanged.
- Requesters must hold req, we, addr and wdata stable from assertion until ack. Changes after the IDLE sample are ignored.
- Only one ack can ever be high in a given cycle.

Optional Feature:
- Macro: TEST_RAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a simultaneous request, the requester that was not granted most recently wins.
  - The pointer updates at every grant.
  - A single request is always granted immediately.
- Undefined: fixed dbg-over-cpu priority; the pointer logic is absent.

Decomposition:
- Shared include src/test_ram_arb_defines.vinc holds:
  - state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3);
  - owner encodings (OWN_CPU=1'b0, OWN_DBG=1'b1);
  - OPEN_BUS_DATA=8'hFF.
- Sub-module test_ram_arb_pick: combinational grant select from two reqs plus the last-owner pointer. It contains the TEST_RAM_ARB_RR_EN conditional logic.

Test Plan:
- Single cpu read, RAM_LATENCY=1, mem[16'h1234]=8'hA5, cpu_addr=24'h001234:
  - ram_en is high exactly once, at cycle 1;
  - cpu_ack is high at cycle 3 with cpu_rdata=8'hA5;
  - dbg_ack stays 0.
- dbg write 8'h3C to 24'h000010, then dbg read of the same address:
  - dbg_rdata=8'h3C;
  - cpu_rdata is unchanged from its reset value 0.
- cpu_req and dbg_req rise in the same cycle, both held:
  - without the macro, dbg is acked first, then cpu 4 cycles later;
  - with TEST_RAM_ARB_RR_EN and the pointer at cpu, dbg wins first. A repeat contention then grants cpu first.
- cpu read of 24'h010000 (out of range):
  - no ram_en pulse;
  - cpu_ack at cycle 3 with cpu_rdata=8'hFF;
  - a write to the same address leaves the RAM untouched.
- RAM_LATENCY=3, cpu read with req held continuously:
  - acks at cycles 5, 11, 17;
  - ram_en pulses at cycles 1, 7, 13.
- rst asserted during WAIT of a cpu read:
  - outputs go to 0 immediately, asynchronously;
  - no cpu_ack is produced;
  - after release, a new request completes normally.
